// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-port req/ack arbiter in front of the single-port fabric register file
module regfile_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic [1:0]        state;
  logic              last_gnt;
  logic              gnt;
  logic              cmd_we;

  logic              grant_valid;
  logic              grant_sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Ties go to A under fixed priority, otherwise to whichever port did not win last.
  always_comb begin
    grant_valid = a_req | b_req;
    if (a_req && b_req) begin
      grant_sel = FIXED_PRIO ? GNT_A : ~last_gnt;
    end else begin
      grant_sel = b_req ? GNT_B : GNT_A;
    end
    win_we    = (grant_sel == GNT_B) ? b_we    : a_we;
    win_addr  = (grant_sel == GNT_B) ? b_addr  : a_addr;
    win_wdata = (grant_sel == GNT_B) ? b_wdata : a_wdata;
  end

  assign busy = (state != S_IDLE);

  // mem_addr/mem_wdata double as the latched command and hold until the next grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      last_gnt  <= GNT_B;
      gnt       <= GNT_A;
      cmd_we    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            gnt       <= grant_sel;
            last_gnt  <= grant_sel;
            cmd_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_wr_en <= win_we;
            mem_rd_en <= ~win_we;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_wr_en <= 1'b0;
          mem_rd_en <= 1'b0;
          if (cmd_we) begin
            a_ack <= (gnt == GNT_A);
            b_ack <= (gnt == GNT_B);
            state <= S_RESP;
          end else begin
            state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (gnt == GNT_B) begin
            b_rdata <= mem_rdata;
          end else begin
            a_rdata <= mem_rdata;
          end
          a_ack <= (gnt == GNT_A);
          b_ack <= (gnt == GNT_B);
          state <= S_RESP;
        end
        default: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed vector bench for regfile_arbiter (round-robin and fixed-priority instances)
module tb_regfile_arbiter;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       mem_init = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;

  logic       u0_a_ack, u0_b_ack, u0_wr, u0_rd, u0_busy;
  logic [7:0] u0_a_rdata, u0_b_rdata, u0_wdata, u0_mrdata;
  logic [3:0] u0_addr;
  logic       u1_a_ack, u1_b_ack, u1_wr, u1_rd, u1_busy;
  logic [7:0] u1_a_rdata, u1_b_rdata, u1_wdata, u1_mrdata;
  logic [3:0] u1_addr;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(1'b0)) u0 (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(u0_a_ack), .a_rdata(u0_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(u0_b_ack), .b_rdata(u0_b_rdata),
    .mem_wr_en(u0_wr), .mem_rd_en(u0_rd), .mem_addr(u0_addr), .mem_wdata(u0_wdata),
    .mem_rdata(u0_mrdata), .busy(u0_busy)
  );

  regfile_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(1'b1)) u1 (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(u1_a_ack), .a_rdata(u1_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(u1_b_ack), .b_rdata(u1_b_rdata),
    .mem_wr_en(u1_wr), .mem_rd_en(u1_rd), .mem_addr(u1_addr), .mem_wdata(u1_wdata),
    .mem_rdata(u1_mrdata), .busy(u1_busy)
  );

  // Register file models: preloaded with 0x80|addr, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= 8'h80 | 8'(i);
        mem1[i] <= 8'h80 | 8'(i);
      end
    end else begin
      if (u0_wr) mem0[u0_addr] <= u0_wdata;
      if (u0_rd) u0_mrdata <= mem0[u0_addr];
      if (u1_wr) mem1[u1_addr] <= u1_wdata;
      if (u1_rd) u1_mrdata <= mem1[u1_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  // One isolated access on u0, checking strobe, ack latency and read data.
  task automatic do_access(input vec_t v, input int idx);
    if (v.port) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    @(negedge clk);
    check($sformatf("vec%0d_strobe", idx), 32'(v.we ? u0_wr : u0_rd), 32'd1);
    check($sformatf("vec%0d_addr", idx), 32'(u0_addr), 32'(v.addr));
    if (v.we) check($sformatf("vec%0d_wdata", idx), 32'(u0_wdata), 32'(v.wdata));
    if (!v.we) begin
      @(negedge clk);
      check($sformatf("vec%0d_early_ack", idx), 32'(u0_a_ack | u0_b_ack), 32'd0);
    end
    @(negedge clk);
    check($sformatf("vec%0d_ack", idx), 32'(v.port ? u0_b_ack : u0_a_ack), 32'd1);
    check($sformatf("vec%0d_other_ack", idx), 32'(v.port ? u0_a_ack : u0_b_ack), 32'd0);
    if (!v.we)
      check($sformatf("vec%0d_rdata", idx), 32'(v.port ? u0_b_rdata : u0_a_rdata), 32'(v.exp_rdata));
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_idle", idx), 32'(u0_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] order [6];
    int ng, na, nb, nboth, nrd, nwr, nbad_addr, nrdata_bad;

    vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 4'h7, 8'h11, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 4'h7, 8'h00, 8'h11};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h3C};
    vecs[6] = '{1'b0, 1'b1, 4'hF, 8'h5A, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 4'hF, 8'h00, 8'h5A};
    vecs[8] = '{1'b0, 1'b0, 4'h7, 8'h00, 8'h11};

    repeat (3) @(negedge clk);
    check("rst_acks", 32'({u0_a_ack, u0_b_ack}), 32'd0);
    check("rst_strobes", 32'({u0_wr, u0_rd}), 32'd0);
    check("rst_busy", 32'(u0_busy), 32'd0);
    check("rst_addr_wdata", 32'({u0_addr, u0_wdata}), 32'd0);
    check("rst_rdata", 32'({u0_a_rdata, u0_b_rdata}), 32'd0);
    nreset = 1'b1;
    mem_init = 1'b0;
    @(negedge clk);

    // Reset in the middle of a B read: abandoned, then A wins the tie after release.
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h5;
    @(negedge clk);
    check("midrst_rd_before", 32'(u0_rd), 32'd1);
    nreset = 1'b0;
    #1;
    check("midrst_strobes", 32'({u0_wr, u0_rd}), 32'd0);
    check("midrst_acks", 32'({u0_a_ack, u0_b_ack}), 32'd0);
    check("midrst_busy", 32'(u0_busy), 32'd0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h9; a_wdata = 8'h77;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("postrst_a_first_wr", 32'(u0_wr), 32'd1);
    check("postrst_a_first_addr", 32'(u0_addr), 32'h9);
    @(negedge clk);
    check("postrst_a_ack", 32'({u0_a_ack, u0_b_ack}), 32'b10);
    a_req = 1'b0;
    @(negedge clk);
    check("postrst_idle", 32'(u0_busy), 32'd0);
    @(negedge clk);
    check("postrst_b_rd", 32'({u0_rd, u0_addr}), 32'h15);
    @(negedge clk);
    @(negedge clk);
    check("postrst_b_ack", 32'({u0_a_ack, u0_b_ack}), 32'b01);
    check("postrst_b_rdata", 32'(u0_b_rdata), 32'h85);
    b_req = 1'b0;
    @(negedge clk);

    // Round-robin: both ports write continuously for six grants.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h1; a_wdata = 8'hAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'h2; b_wdata = 8'hBB;
    ng = 0; na = 0; nb = 0; nboth = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (u0_wr) begin
        if (ng < 6) order[ng] = u0_addr;
        ng++;
      end
      if (u0_a_ack) na++;
      if (u0_b_ack) nb++;
      if (u0_a_ack && u0_b_ack) nboth++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr_grants", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("rr_order%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    check("rr_a_acks", 32'(na), 32'd3);
    check("rr_b_acks", 32'(nb), 32'd3);
    check("rr_both_acks", 32'(nboth), 32'd0);

    // Fixed priority: A back-to-back reads starve B until a_req drops.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h6;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'h4; b_wdata = 8'h44;
    nrd = 0; nwr = 0; na = 0; nb = 0; nbad_addr = 0; nrdata_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (u1_rd) begin
        nrd++;
        if (u1_addr != 4'h6) nbad_addr++;
      end
      if (u1_wr) nwr++;
      if (u1_a_ack) begin
        na++;
        if (u1_a_rdata != 8'h86) nrdata_bad++;
      end
      if (u1_b_ack) nb++;
    end
    a_req = 1'b0;
    check("fp_a_reads", 32'(nrd), 32'd3);
    check("fp_a_acks", 32'(na), 32'd3);
    check("fp_b_starved_wr", 32'(nwr), 32'd0);
    check("fp_b_starved_ack", 32'(nb), 32'd0);
    check("fp_rd_addr", 32'(nbad_addr), 32'd0);
    check("fp_a_rdata", 32'(nrdata_bad), 32'd0);
    @(negedge clk);
    check("fp_b_granted", 32'({u1_wr, u1_addr}), 32'h14);
    @(negedge clk);
    check("fp_b_ack", 32'(u1_b_ack), 32'd1);
    b_req = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i], i);
      if (i == 2) check("a_rdata_hold", 32'(u0_a_rdata), 32'hA5);
      if (i == 5) check("xport_b_rdata_hold", 32'(u0_b_rdata), 32'h11);
    end

    // Command change after grant is ignored.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'hF;
    @(negedge clk);
    check("cmdchg_rd", 32'(u0_rd), 32'd1);
    a_addr = 4'h0;
    @(negedge clk);
    check("cmdchg_addr", 32'(u0_addr), 32'hF);
    @(negedge clk);
    check("cmdchg_ack", 32'(u0_a_ack), 32'd1);
    check("cmdchg_rdata", 32'(u0_a_rdata), 32'h5A);
    a_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the 16x8 single-port fabric register file (mem write/read strobes, 4-bit address, 1-cycle registered read data) between two requesters: port A (MSS/APB bridge side) and port B (fabric engine).
- Serialises accesses with a req/ack handshake, arbitrates round-robin or fixed-priority, and returns read data to the winning requester.
- Sits between the bus slaves and the register file; it is the only driver of the register file strobes.

Parameters:
- ADDR_W, 4, register file address width
- DATA_W, 8, data width
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins ties

Ports:
- clk  in  1  clock
- nreset  in  1  reset, asynchronous, active-low
- a_req  in  1  port A access request; held until a_ack
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  DATA_W  port A read data, valid when a_ack=1 for a read
- b_req / b_we / b_addr / b_wdata / b_ack / b_rdata  same as port A, for port B
- mem_wr_en  out  1  register file write strobe
- mem_rd_en  out  1  register file read strobe
- mem_addr  out  ADDR_W  register file address
- mem_wdata  out  DATA_W  register file write data
- mem_rdata  in  DATA_W  register file read data, valid the cycle after mem_rd_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - All outputs are 0: acks, strobes, mem_addr, mem_wdata, a_rdata, b_rdata, busy.
  - Round-robin pointer last_gnt = B, so A wins the first tie.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. A write already strobed into the register file stays committed.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high and FIXED_PRIO=1, grant A.
  - If both are high and FIXED_PRIO=0, grant the port not equal to last_gnt.
  - On grant, latch we/addr/wdata of the winner into cmd registers, update last_gnt, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - Write: mem_wr_en=1 and mem_wdata = latched wdata; next state RESP.
  - Read: mem_rd_en=1; next state RDWAIT.
  - Strobes are registered outputs, high only in ACCESS.
- RDWAIT (1 cycle): capture mem_rdata into the winner's rdata register; next state RESP.
- RESP (1 cycle): winner's ack=1; next state IDLE.
- Latency, with req first sampled high in IDLE at edge N:
  - Strobe high during cycle N+1.
  - Write ack high during cycle N+2.
  - Read ack plus rdata during cycle N+3.
  - Throughput: one write per 3 cycles, one read per 4 cycles.
- Handshake rules:
  - Requester holds req and command stable until it samples ack=1.
  - Requester clears req at that same edge.
  - req is ignored outside IDLE; a req still high in IDLE is treated as a new request.
  - Command changes after grant are ignored, because the command is latched.
  - A req dropped early by the requester is a protocol violation. The latched access still completes and ack still pulses.
- rdata holds its last value until the next read completes for that port. It is not cleared on writes or on the other port's accesses.
- The loser's req stays pending and is granted in the IDLE immediately after the winner's RESP. With continuous requests on both ports, round-robin alternates strictly A,B,A,B.
- Address wrap: addresses are ADDR_W bits and are used verbatim; there is no range check.
- Only one strobe is ever high at a time, and never both acks.

Test Plan:
- Reset: assert nreset=0 mid-ACCESS of a B read -> strobes, acks and busy = 0 immediately; after release a_req wins first (last_gnt reset = B).
- Single write then read on A: write addr 0x3, data 0xA5 -> mem_wr_en pulse at N+1, a_ack at N+2. Then read addr 0x3 -> mem_rd_en at N+1, a_ack with a_rdata=0xA5 at N+3.
- Simultaneous reqs, FIXED_PRIO=0: both ports request writes continuously (A to 0x1, B to 0x2) for 6 grants -> grant order A,B,A,B,A,B; exactly one ack per RESP.
- Simultaneous reqs, FIXED_PRIO=1: A issues back-to-back reads, B holds a_req-style request -> A granted every time; B starves while A is requesting and is granted on the first IDLE where a_req=0.
- Command change after grant: A reads 0xF, then changes a_addr to 0x0 during ACCESS -> mem_addr stays 0xF and a_rdata = mem[0xF].
- Cross-port data: B writes 0x3C to 0x0, then A reads 0x0 -> a_rdata=0x3C; b_rdata unchanged from its prior value.
